// File: rtl/multi_issue_dispatch.sv
// rtl/multi_issue_dispatch.sv - in-order multi-issue dispatch queue with scoreboard (optional ISSUE_WB_BYPASS_EN)
module multi_issue_dispatch #(
    parameter int NR_ISSUE  = 2,
    parameter int DEPTH     = 8,
    parameter int NR_FU     = 4,
    parameter int NR_WB     = 4,
    parameter int PAYLOAD_W = 64,
    parameter int FU_W      = (NR_FU > 1) ? $clog2(NR_FU) : 1,
    parameter int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          flush_i,
    input  logic                          enq_valid_i,
    output logic                          enq_ready_o,
    input  logic [FU_W-1:0]               enq_fu_i,
    input  logic [4:0]                    enq_rd_i,
    input  logic                          enq_rd_we_i,
    input  logic [4:0]                    enq_rs1_i,
    input  logic [4:0]                    enq_rs2_i,
    input  logic [PAYLOAD_W-1:0]          enq_payload_i,
    input  logic [NR_FU-1:0]              fu_ready_i,
    output logic [NR_ISSUE-1:0]           disp_valid_o,
    output logic [NR_ISSUE*FU_W-1:0]      disp_fu_o,
    output logic [NR_ISSUE*5-1:0]         disp_rd_o,
    output logic [NR_ISSUE*PAYLOAD_W-1:0] disp_payload_o,
    input  logic [NR_WB-1:0]              wb_valid_i,
    input  logic [NR_WB*5-1:0]            wb_rd_i,
    output logic [CNT_W-1:0]              count_o,
    output logic                          stall_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [FU_W-1:0]      mem_fu      [DEPTH];
    logic [4:0]           mem_rd      [DEPTH];
    logic                 mem_we      [DEPTH];
    logic [4:0]           mem_rs1     [DEPTH];
    logic [4:0]           mem_rs2     [DEPTH];
    logic [PAYLOAD_W-1:0] mem_payload [DEPTH];

    logic [PTR_W-1:0] head, tail;
    logic [CNT_W-1:0] count, n_disp;
    logic [31:0]      busy, busy_chk, wb_mask, set_mask;
    logic             enq_fire;

    logic [2**FU_W-1:0]  fu_rdy;
    logic [NR_ISSUE-1:0] lane_ok, disp;
    logic [FU_W-1:0]     l_fu  [NR_ISSUE];
    logic [4:0]          l_rd  [NR_ISSUE];
    logic                l_we  [NR_ISSUE];
    logic [4:0]          l_rs1 [NR_ISSUE];
    logic [4:0]          l_rs2 [NR_ISSUE];

    always_comb begin
        wb_mask = '0;
        for (int k = 0; k < NR_WB; k++)
            if (wb_valid_i[k]) wb_mask[wb_rd_i[k*5 +: 5]] = 1'b1;
    end

`ifdef ISSUE_WB_BYPASS_EN
    assign busy_chk = busy & ~wb_mask;
`else
    assign busy_chk = busy;
`endif

    // Classes beyond NR_FU are treated as never ready.
    always_comb begin
        fu_rdy = '0;
        for (int i = 0; i < NR_FU; i++) fu_rdy[i] = fu_ready_i[i];
    end

    for (genvar g = 0; g < NR_ISSUE; g++) begin : g_lane
        logic [PTR_W-1:0] idx;
        assign idx      = head + PTR_W'(g);
        assign l_fu[g]  = mem_fu[idx];
        assign l_rd[g]  = mem_rd[idx];
        assign l_we[g]  = mem_we[idx];
        assign l_rs1[g] = mem_rs1[idx];
        assign l_rs2[g] = mem_rs2[idx];
        assign lane_ok[g] = (count > CNT_W'(g)) && fu_rdy[l_fu[g]]
                         && !busy_chk[l_rs1[g]] && !busy_chk[l_rs2[g]]
                         && !(l_we[g] && busy_chk[l_rd[g]]);
        assign disp_fu_o[g*FU_W +: FU_W]                = l_fu[g];
        assign disp_rd_o[g*5 +: 5]                      = l_rd[g];
        assign disp_payload_o[g*PAYLOAD_W +: PAYLOAD_W] = mem_payload[idx];
    end

    assign disp[0] = lane_ok[0] && !flush_i;

    if (NR_ISSUE > 1) begin : g_pair
        logic l0_wr, dep;
        assign l0_wr = l_we[0] && (l_rd[0] != 5'd0);
        assign dep   = l0_wr && (l_rs1[1] == l_rd[0] || l_rs2[1] == l_rd[0]
                              || l_rd[1] == l_rd[0]);
        assign disp[1] = disp[0] && lane_ok[1] && (l_fu[1] != l_fu[0]) && !dep;
    end

    always_comb begin
        n_disp   = '0;
        set_mask = '0;
        for (int i = 0; i < NR_ISSUE; i++) begin
            n_disp = n_disp + CNT_W'(disp[i]);
            if (disp[i] && l_we[i]) set_mask[l_rd[i]] = 1'b1;
        end
        set_mask[0] = 1'b0;
    end

    assign enq_ready_o  = (count != CNT_W'(DEPTH));
    assign enq_fire     = enq_valid_i && enq_ready_o && !flush_i;
    assign disp_valid_o = disp;
    assign count_o      = count;
    assign stall_o      = (count != '0) && !flush_i && !disp[0];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            busy  <= '0;
        end else begin
            // Set after clear so a same-cycle dispatch keeps its destination busy.
            busy <= ((busy & ~wb_mask) | set_mask) & 32'hFFFF_FFFE;
            if (flush_i) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (enq_fire) tail <= tail + PTR_W'(1);
                head  <= head + PTR_W'(n_disp);
                count <= count + CNT_W'(enq_fire) - n_disp;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq_fire) begin
            mem_fu[tail]      <= enq_fu_i;
            mem_rd[tail]      <= enq_rd_i;
            mem_we[tail]      <= enq_rd_we_i;
            mem_rs1[tail]     <= enq_rs1_i;
            mem_rs2[tail]     <= enq_rs2_i;
            mem_payload[tail] <= enq_payload_i;
        end
    end
endmodule
